// File: rtl/dump_pkg.sv
// Shared types for the state readback engine: stream tag encoding and FSM state encoding.
package dump_pkg;

  localparam int unsigned TAG_W = 2;
  localparam int unsigned ST_W  = 3;

  typedef enum logic [TAG_W-1:0] {
    TAG_REG  = 2'd0,
    TAG_MEM  = 2'd1,
    TAG_CSUM = 2'd2
  } tag_e;

  // FSM state encoding
  localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [ST_W-1:0] ST_RF_REQ   = 3'd1;
  localparam logic [ST_W-1:0] ST_RF_OUT   = 3'd2;
  localparam logic [ST_W-1:0] ST_DM_REQ   = 3'd3;
  localparam logic [ST_W-1:0] ST_DM_OUT   = 3'd4;
  localparam logic [ST_W-1:0] ST_CSUM_OUT = 3'd5;
  localparam logic [ST_W-1:0] ST_DONE     = 3'd6;

endpackage

// File: rtl/dump_csum.sv
// Running modulo-2^XLEN sum of handshaked stream words; only built with DUMP_CHECKSUM_EN.
module dump_csum #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            add_en,
  input  logic [XLEN-1:0] add_data,
  output logic [XLEN-1:0] sum
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + add_data;
    end
  end

endmodule

// File: rtl/mem_dump_unit.sv
// Post-run readback: streams the register file, then a data-memory window, over valid/ready.
// Define DUMP_CHECKSUM_EN to append a trailing checksum word (tag 2).
module mem_dump_unit
  import dump_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DMEM_AW  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [DMEM_AW-1:0]          mem_base,
  input  logic [DMEM_AW:0]            mem_words,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(NUM_REGS)-1:0] rf_raddr,
  input  logic [XLEN-1:0]             rf_rdata,
  output logic [DMEM_AW-1:0]          dm_raddr,
  input  logic [XLEN-1:0]             dm_rdata,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic [XLEN-1:0]             dout_data,
  output logic [TAG_W-1:0]            dout_tag,
  output logic [DMEM_AW-1:0]          dout_index,
  output logic                        dout_last
);

  localparam int unsigned RF_AW = $clog2(NUM_REGS);
  localparam int unsigned IDX_W = DMEM_AW + 1;
`ifdef DUMP_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic [ST_W-1:0]    state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [DMEM_AW-1:0] base_q, base_nxt;
  logic [IDX_W-1:0]   words_q, words_nxt;
  logic [RF_AW-1:0]   rf_raddr_nxt;
  logic [DMEM_AW-1:0] dm_raddr_nxt, index_nxt;
  logic [TAG_W-1:0]   tag_nxt;
  logic               busy_nxt, done_nxt, valid_nxt, last_nxt;
  logic               hs, rf_last, mem_last, no_mem, enter_post;

  assign hs       = dout_valid && dout_ready;
  assign rf_last  = (idx == IDX_W'(NUM_REGS - 1));
  assign mem_last = (idx == (words_q - IDX_W'(1)));
  assign no_mem   = (words_q == '0);

  // Next state and next registered outputs
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    base_nxt     = base_q;
    words_nxt    = words_q;
    rf_raddr_nxt = rf_raddr;
    dm_raddr_nxt = dm_raddr;
    index_nxt    = dout_index;
    tag_nxt      = dout_tag;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    valid_nxt    = dout_valid;
    last_nxt     = dout_last;
    enter_post   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          base_nxt     = mem_base;
          words_nxt    = mem_words;
          idx_nxt      = '0;
          rf_raddr_nxt = '0;
          busy_nxt     = 1'b1;
          state_nxt    = ST_RF_REQ;
        end
      end
      ST_RF_REQ: begin
        valid_nxt = 1'b1;
        tag_nxt   = TAG_REG;
        index_nxt = DMEM_AW'(idx);
        last_nxt  = !CSUM_EN && rf_last && no_mem;
        state_nxt = ST_RF_OUT;
      end
      ST_RF_OUT: begin
        if (hs) begin
          valid_nxt = 1'b0;
          last_nxt  = 1'b0;
          if (rf_last) begin
            idx_nxt = '0;
            if (no_mem) begin
              enter_post = 1'b1;
            end else begin
              dm_raddr_nxt = base_q;
              state_nxt    = ST_DM_REQ;
            end
          end else begin
            idx_nxt      = idx + IDX_W'(1);
            rf_raddr_nxt = RF_AW'(idx + IDX_W'(1));
            state_nxt    = ST_RF_REQ;
          end
        end
      end
      ST_DM_REQ: begin
        valid_nxt = 1'b1;
        tag_nxt   = TAG_MEM;
        index_nxt = dm_raddr;
        last_nxt  = !CSUM_EN && mem_last;
        state_nxt = ST_DM_OUT;
      end
      ST_DM_OUT: begin
        if (hs) begin
          valid_nxt = 1'b0;
          last_nxt  = 1'b0;
          if (mem_last) begin
            enter_post = 1'b1;
          end else begin
            idx_nxt      = idx + IDX_W'(1);
            dm_raddr_nxt = dm_raddr + DMEM_AW'(1);
            state_nxt    = ST_DM_REQ;
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      ST_CSUM_OUT: begin
        if (hs) begin
          valid_nxt = 1'b0;
          last_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Leaving the memory phase: checksum word if built in, otherwise finish
    if (enter_post) begin
`ifdef DUMP_CHECKSUM_EN
      valid_nxt = 1'b1;
      tag_nxt   = TAG_CSUM;
      index_nxt = '0;
      last_nxt  = 1'b1;
      state_nxt = ST_CSUM_OUT;
`else
      done_nxt  = 1'b1;
      state_nxt = ST_DONE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      base_q     <= '0;
      words_q    <= '0;
      rf_raddr   <= '0;
      dm_raddr   <= '0;
      dout_index <= '0;
      dout_tag   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      base_q     <= base_nxt;
      words_q    <= words_nxt;
      rf_raddr   <= rf_raddr_nxt;
      dm_raddr   <= dm_raddr_nxt;
      dout_index <= index_nxt;
      dout_tag   <= tag_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      dout_valid <= valid_nxt;
      dout_last  <= last_nxt;
    end
  end

`ifdef DUMP_CHECKSUM_EN
  logic [XLEN-1:0] csum;

  dump_csum #(.XLEN(XLEN)) u_csum (
    .clk      (clk),
    .rst      (rst),
    .clr      (state == ST_IDLE && start),
    .add_en   (hs),
    .add_data (dout_data),
    .sum      (csum)
  );
`endif

  // Data passes straight from the read port while its address is held, so a
  // one-cycle registered memory lands in time as well as a combinational one.
  always_comb begin
    dout_data = '0;
    case (state)
      ST_RF_OUT: dout_data = rf_rdata;
      ST_DM_OUT: dout_data = dm_rdata;
`ifdef DUMP_CHECKSUM_EN
      ST_CSUM_OUT: dout_data = csum;
`endif
      default: dout_data = '0;
    endcase
  end

endmodule

// File: doc/mem_dump_unit.md
# mem_dump_unit

Post-run state readback engine for the pipelined RISC-V core. On a start pulse it walks the register file and a selected data-memory window, and streams every word out over a valid/ready interface. A bench monitor or debug UART bridge consumes this stream. It is the read-side complement of the memory-image load path: it replaces file dumps with an in-hardware, cycle-deterministic state export.

## Interface
- XLEN, 32, data word width
- NUM_REGS, 32, register file entries dumped (index 0..NUM_REGS-1)
- DMEM_AW, 8, data-memory word-address width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin dump; sampled only in IDLE
- mem_base  in  DMEM_AW  first data-memory word address; latched on accepted start
- mem_words  in  DMEM_AW+1  number of memory words to dump (0..2^DMEM_AW); latched on accepted start
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  one-cycle pulse after the final handshake
- rf_raddr  out  $clog2(NUM_REGS)  register file read address
- rf_rdata  in  XLEN  register file read data
- dm_raddr  out  DMEM_AW  data-memory read address
- dm_rdata  in  XLEN  data-memory read data
- dout_valid  out  1  stream word valid
- dout_ready  in  1  consumer ready
- dout_data  out  XLEN  word value
- dout_tag  out  2  0 = register, 1 = memory, 2 = checksum
- dout_index  out  DMEM_AW  register number or absolute memory word address
- dout_last  out  1  marks the final word of the dump

## Operation
- FSM states: IDLE, RF_REQ, RF_OUT, DM_REQ, DM_OUT, CSUM_OUT (macro only), DONE.
- IDLE: start=1 latches mem_base and mem_words, clears the index, and goes to RF_REQ. start in any other state is ignored.
- RF_REQ: drive rf_raddr=idx. Next state is RF_OUT.
- RF_OUT: dout_valid=1 and dout_data=rf_rdata, with rf_raddr held. On a handshake (valid&&ready): if idx==NUM_REGS-1, go to DM_REQ (or to the post-memory state if mem_words==0); else idx++ and go to RF_REQ.
- DM_REQ/DM_OUT: same pattern with dm_raddr=mem_base+idx, tag 1. The address wraps modulo 2^DMEM_AW.
- After the memory words: go to CSUM_OUT if the macro is defined, else to DONE.
- DONE: done=1 for one cycle, then return to IDLE.
- dout_data, dout_tag, dout_index and dout_last are held stable while valid && !ready. Valid never drops without a handshake.
- dout_last=1 on the final emitted word only.
- Read data is sampled one cycle after its address is driven. This tolerates both combinational and single-cycle registered memories.

## Timing
- Reset values: busy=0, done=0, dout_valid=0, dout_last=0, dout_data=0, dout_tag=0, dout_index=0, rf_raddr=0, dm_raddr=0. The FSM goes to IDLE.
- Start is accepted at edge E0. dout_valid first rises after E1.
- With dout_ready held high, each word takes 2 cycles. Total busy cycles = 2*(NUM_REGS+mem_words[+1]) + 1.
- done asserts the cycle after the last handshake. busy deasserts together with done falling.
- A start on the same cycle as done is ignored, because the FSM is not in IDLE.
- rst mid-dump aborts immediately with no done pulse. The next start restarts from register 0.

## Configuration
- DUMP_CHECKSUM_EN defined:
  - Keep a running XLEN-bit sum (mod 2^XLEN) of every handshaked dout_data, cleared on start.
  - Emit one extra word after the memory words: tag 2, index 0, data = sum, dout_last=1.
- Undefined: no accumulator and no CSUM_OUT. dout_last goes on the final memory word, or on register NUM_REGS-1 when mem_words==0.

## Structure
- Package dump_pkg holds:
  - the FSM state enum;
  - the tag enum (TAG_REG, TAG_MEM, TAG_CSUM);
  - the tag width constant.
- Sub-module dump_csum is the accumulator, instantiated only under DUMP_CHECKSUM_EN. Its ports are clk, rst, clr, add_en and add_data, plus sum.
- The rest is a single FSM module with an index counter.

## Test plan
- Registers only: x1..x31 = i*3, mem_words=0, ready=1, macro off. Expect 32 words:
  - tags are 0;
  - data = 0,3,…,93;
  - dout_last only on index 31;
  - done 65 cycles after start.
- Memory window: mem_base=0x10, mem_words=4, dmem[0x10..0x13] = 0xA0..0xA3. Expect:
  - 32 register words, then memory words with index 0x10..0x13 and data 0xA0..0xA3;
  - dout_last on 0x13.
- Wrap: mem_base=0xFE, mem_words=3. Expect memory indices 0xFE, 0xFF, 0x00.
- Backpressure: toggle ready randomly. Expect:
  - outputs stable while stalled;
  - no word dropped or duplicated;
  - sequence identical to the ready=1 run.
- Reset mid-dump: assert rst during register 10. Expect:
  - valid/busy 0 the next cycle and no done pulse;
  - a new start dumps from index 0.
- With DUMP_CHECKSUM_EN and all registers and dmem set to 1, mem_words=4: expect the final tag-2 word = 35 (x0 reads 0) with dout_last=1.
